// File: rtl/jelly_img_absdiff_motion_ctl_pkg.sv
// Shared types and helpers for the absdiff motion controller and its framing FSM.
package jelly_img_absdiff_motion_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } frame_state_t;

  // Unsigned add clamped to the all-ones value of a 'width'-bit register (width < 64).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] s;
    logic [63:0] max;
    max = {64{1'b1}} >> (64 - width);
    s   = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[63:0];
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] a, input int unsigned width);
    return sat_add(a, 64'd1, width);
  endfunction

endpackage

// File: rtl/jelly_img_frame_detect.sv
// SOF/EOF decode and IDLE/WAIT/ACTIVE framing FSM for an image stream.
module jelly_img_frame_detect
  import jelly_img_absdiff_motion_ctl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic cke,
  input  logic enable,
  input  logic line_first,
  input  logic line_last,
  input  logic pixel_first,
  input  logic pixel_last,
  input  logic valid,
  output logic frame_start,
  output logic frame_end,
  output logic frame_abort,
  output logic busy
);

  frame_state_t state;
  logic         sof;
  logic         eof;

  // A start accepted in WAIT needs the run request; a restart in ACTIVE does not.
  always_comb begin
    sof         = cke & valid & line_first & pixel_first;
    eof         = cke & valid & line_last  & pixel_last;
    frame_start = sof & (((state == ST_WAIT) & enable) | (state == ST_ACTIVE));
    frame_abort = sof & (state == ST_ACTIVE);
    frame_end   = eof & ((state == ST_ACTIVE) | frame_start);
    busy        = (state == ST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (cke) begin
      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!enable)          state <= ST_IDLE;
          else if (frame_start) state <= frame_end ? ST_WAIT : ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (frame_end) state <= enable ? ST_WAIT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jelly_img_absdiff_motion_ctl.sv
// Per-frame motion measurement: counts pixels over threshold, sums difference, issues verdict + irq.
module jelly_img_absdiff_motion_ctl
  import jelly_img_absdiff_motion_ctl_pkg::*;
#(
  parameter int SUMDIFF_WIDTH = 10,
  parameter int COUNT_WIDTH   = 24,
  parameter int ACC_WIDTH     = 32,
  parameter int FCNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic                     ctl_enable,
  input  logic                     ctl_update,
  input  logic [SUMDIFF_WIDTH-1:0] param_pix_th,
  input  logic [COUNT_WIDTH-1:0]   param_frame_th,
  input  logic                     s_img_line_first,
  input  logic                     s_img_line_last,
  input  logic                     s_img_pixel_first,
  input  logic                     s_img_pixel_last,
  input  logic                     s_img_de,
  input  logic [SUMDIFF_WIDTH-1:0] s_img_sumdiff,
  input  logic                     s_img_valid,
  output logic                     ctl_update_ack,
  output logic                     stat_busy,
  output logic                     stat_motion,
  output logic [COUNT_WIDTH-1:0]   stat_motion_pixels,
  output logic [ACC_WIDTH-1:0]     stat_sum,
  output logic [FCNT_WIDTH-1:0]    stat_frame_count,
  output logic [FCNT_WIDTH-1:0]    stat_abort_count,
  output logic                     irq
);

  logic                     frame_start;
  logic                     frame_end;
  logic                     frame_abort;
  logic                     load_params;
  logic                     measure;
  logic                     pending;
  logic [SUMDIFF_WIDTH-1:0] shadow_pix_th;
  logic [SUMDIFF_WIDTH-1:0] pix_th_now;
  logic [COUNT_WIDTH-1:0]   shadow_frame_th;
  logic [COUNT_WIDTH-1:0]   frame_th_now;
  logic [COUNT_WIDTH-1:0]   count_reg;
  logic [COUNT_WIDTH-1:0]   count_base;
  logic [COUNT_WIDTH-1:0]   count_next;
  logic [ACC_WIDTH-1:0]     sum_reg;
  logic [ACC_WIDTH-1:0]     sum_base;
  logic [ACC_WIDTH-1:0]     sum_next;

  jelly_img_frame_detect u_frame_detect (
    .clk         (clk),
    .reset       (reset),
    .cke         (cke),
    .enable      (ctl_enable),
    .line_first  (s_img_line_first),
    .line_last   (s_img_line_last),
    .pixel_first (s_img_pixel_first),
    .pixel_last  (s_img_pixel_last),
    .valid       (s_img_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_abort (frame_abort),
    .busy        (stat_busy)
  );

  // The SOF beat is measured with the thresholds it loads, so the shadow is bypassed that cycle.
  always_comb begin
    load_params  = frame_start & (pending | ctl_update);
    pix_th_now   = load_params ? param_pix_th   : shadow_pix_th;
    frame_th_now = load_params ? param_frame_th : shadow_frame_th;
    measure      = cke & s_img_valid & s_img_de & (stat_busy | frame_start);
    count_base   = frame_start ? '0 : count_reg;
    sum_base     = frame_start ? '0 : sum_reg;
    count_next   = count_base;
    sum_next     = sum_base;
    if (measure) begin
      sum_next = ACC_WIDTH'(sat_add(64'(sum_base), 64'(s_img_sumdiff), ACC_WIDTH));
      if (s_img_sumdiff > pix_th_now) begin
        count_next = COUNT_WIDTH'(sat_inc(64'(count_base), COUNT_WIDTH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending            <= 1'b0;
      shadow_pix_th      <= '0;
      shadow_frame_th    <= '0;
      count_reg          <= '0;
      sum_reg            <= '0;
      ctl_update_ack     <= 1'b0;
      irq                <= 1'b0;
      stat_motion        <= 1'b0;
      stat_motion_pixels <= '0;
      stat_sum           <= '0;
      stat_frame_count   <= '0;
      stat_abort_count   <= '0;
    end else if (cke) begin
      ctl_update_ack <= load_params;
      irq            <= frame_end;
      count_reg      <= count_next;
      sum_reg        <= sum_next;

      if (load_params) begin
        shadow_pix_th   <= param_pix_th;
        shadow_frame_th <= param_frame_th;
        pending         <= 1'b0;
      end else if (ctl_update) begin
        pending <= 1'b1;
      end

      if (frame_end) begin
        stat_motion_pixels <= count_next;
        stat_sum           <= sum_next;
        stat_motion        <= (count_next >= frame_th_now);
        stat_frame_count   <= stat_frame_count + 1'b1;
      end

      if (frame_abort) begin
        stat_abort_count <= stat_abort_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jelly_img_absdiff_motion_ctl.sv
// Self-checking bench: frame-level reference model with randomized frames, stalls and updates.
module tb_jelly_img_absdiff_motion_ctl;

  localparam int SW   = 10;
  localparam int CW   = 5;
  localparam int AW   = 12;
  localparam int FW   = 16;
  localparam int CMAX = (1 << CW) - 1;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cke = 1'b1;
  logic          ctl_enable = 1'b0;
  logic          ctl_update = 1'b0;
  logic [SW-1:0] param_pix_th = '0;
  logic [CW-1:0] param_frame_th = '0;
  logic          s_img_line_first = 1'b0;
  logic          s_img_line_last = 1'b0;
  logic          s_img_pixel_first = 1'b0;
  logic          s_img_pixel_last = 1'b0;
  logic          s_img_de = 1'b0;
  logic [SW-1:0] s_img_sumdiff = '0;
  logic          s_img_valid = 1'b0;
  logic          ctl_update_ack;
  logic          stat_busy;
  logic          stat_motion;
  logic [CW-1:0] stat_motion_pixels;
  logic [AW-1:0] stat_sum;
  logic [FW-1:0] stat_frame_count;
  logic [FW-1:0] stat_abort_count;
  logic          irq;

  always #5 clk = ~clk;

  jelly_img_absdiff_motion_ctl #(
    .SUMDIFF_WIDTH (SW),
    .COUNT_WIDTH   (CW),
    .ACC_WIDTH     (AW),
    .FCNT_WIDTH    (FW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cke                (cke),
    .ctl_enable         (ctl_enable),
    .ctl_update         (ctl_update),
    .param_pix_th       (param_pix_th),
    .param_frame_th     (param_frame_th),
    .s_img_line_first   (s_img_line_first),
    .s_img_line_last    (s_img_line_last),
    .s_img_pixel_first  (s_img_pixel_first),
    .s_img_pixel_last   (s_img_pixel_last),
    .s_img_de           (s_img_de),
    .s_img_sumdiff      (s_img_sumdiff),
    .s_img_valid        (s_img_valid),
    .ctl_update_ack     (ctl_update_ack),
    .stat_busy          (stat_busy),
    .stat_motion        (stat_motion),
    .stat_motion_pixels (stat_motion_pixels),
    .stat_sum           (stat_sum),
    .stat_frame_count   (stat_frame_count),
    .stat_abort_count   (stat_abort_count),
    .irq                (irq)
  );

  int checks = 0;
  int errors = 0;
  int irq_cnt = 0;
  int ack_cnt = 0;

  // Reference model state (frame level)
  int   m_pix, m_fth, m_cnt_st, m_sum_st, m_fc, m_ac, m_ack, m_irq;
  logic m_pend, m_mot_st, m_active;
  int   px_sd[64];
  logic px_de[64];

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_pix = 0; m_fth = 0; m_cnt_st = 0; m_sum_st = 0; m_fc = 0; m_ac = 0;
    m_ack = 0; m_irq = 0; m_pend = 1'b0; m_mot_st = 1'b0; m_active = 1'b0;
    irq_cnt = 0; ack_cnt = 0;
  endtask

  task automatic tick();
    logic c;
    c = cke;
    @(posedge clk);
    #1;
    if (c && irq) irq_cnt++;
    if (c && ctl_update_ack) ack_cnt++;
  endtask

  task automatic drive_beat(input logic lf, input logic ll, input logic pf, input logic pl,
                            input logic dv, input int sd, input logic upd);
    s_img_line_first  = lf;
    s_img_line_last   = ll;
    s_img_pixel_first = pf;
    s_img_pixel_last  = pl;
    s_img_de          = dv;
    s_img_sumdiff     = SW'(sd);
    s_img_valid       = 1'b1;
    ctl_update        = upd;
    tick();
    s_img_valid = 1'b0;
    ctl_update  = 1'b0;
  endtask

  // Clock-disabled cycle with garbage on every input; nothing may change.
  task automatic stall();
    cke               = 1'b0;
    s_img_valid       = 1'b1;
    s_img_line_first  = 1'($urandom_range(0, 1));
    s_img_line_last   = 1'($urandom_range(0, 1));
    s_img_pixel_first = 1'($urandom_range(0, 1));
    s_img_pixel_last  = 1'($urandom_range(0, 1));
    s_img_de          = 1'($urandom_range(0, 1));
    s_img_sumdiff     = SW'($urandom);
    ctl_update        = 1'($urandom_range(0, 1));
    tick();
    cke         = 1'b1;
    s_img_valid = 1'b0;
    ctl_update  = 1'b0;
  endtask

  task automatic pulse_update(input int pix, input int fth);
    param_pix_th   = SW'(pix);
    param_frame_th = CW'(fth);
    ctl_update     = 1'b1;
    tick();
    ctl_update = 1'b0;
    m_pend     = 1'b1;
  endtask

  task automatic model_sof(input logic upd_now);
    if (m_active) m_ac++;
    if (m_pend || upd_now) begin
      m_pix  = int'(param_pix_th);
      m_fth  = int'(param_frame_th);
      m_pend = 1'b0;
      m_ack++;
    end
    m_active = 1'b1;
  endtask

  task automatic run_frame(input int w, input int h, input int upd_idx, input int new_pix,
                           input int new_fth, input int drop_idx, input logic do_stall,
                           output logic irq_eof, output logic busy_sof);
    int n, cnt, sum;
    n = w * h; cnt = 0; sum = 0; irq_eof = 1'b0; busy_sof = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (do_stall && i > 0 && $urandom_range(0, 3) == 0) stall();
      if (i == upd_idx) begin
        param_pix_th   = SW'(new_pix);
        param_frame_th = CW'(new_fth);
      end
      if (i == drop_idx) ctl_enable = 1'b0;
      if (i == 0) model_sof(upd_idx == 0);
      if (px_de[i]) begin
        sum = (sum + px_sd[i] > AMAX) ? AMAX : sum + px_sd[i];
        if (px_sd[i] > m_pix) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
      end
      drive_beat((i / w) == 0, (i / w) == h - 1, (i % w) == 0, (i % w) == w - 1,
                 px_de[i], px_sd[i], i == upd_idx);
      if (i == 0) busy_sof = stat_busy;
      if (i == n - 1) irq_eof = irq;
    end
    m_active = 1'b0;
    m_cnt_st = cnt;
    m_sum_st = sum;
    m_mot_st = (cnt >= m_fth);
    m_fc     = (m_fc + 1) % (1 << FW);
    m_irq++;
    if (upd_idx > 0) m_pend = 1'b1;
  endtask

  // Frame of n beats that never reaches its end (8 pixels wide, single line).
  task automatic start_partial(input int n);
    for (int i = 0; i < n; i++) begin
      if (i == 0) model_sof(1'b0);
      drive_beat(1'b1, 1'b0, (i % 8) == 0, (i % 8) == 7, 1'b1, $urandom_range(0, 1023), 1'b0);
    end
  endtask

  task automatic fill(input int n, input int sd);
    for (int i = 0; i < n; i++) begin
      px_sd[i] = sd;
      px_de[i] = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (stat_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", stat_busy); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b want 0", irq); end
    checks++; if (ctl_update_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b want 0", ctl_update_ack); end
    checks++; if (stat_motion !== 1'b0) begin errors++; $display("FAIL reset_motion got %0b want 0", stat_motion); end
    checks++; if (stat_motion_pixels !== '0) begin errors++; $display("FAIL reset_pixels got %0d want 0", stat_motion_pixels); end
    checks++; if (stat_sum !== '0) begin errors++; $display("FAIL reset_sum got %0d want 0", stat_sum); end
    checks++; if (stat_frame_count !== '0) begin errors++; $display("FAIL reset_fcnt got %0d want 0", stat_frame_count); end
    checks++; if (stat_abort_count !== '0) begin errors++; $display("FAIL reset_acnt got %0d want 0", stat_abort_count); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic ie, bs;
    ctl_enable = 1'b1;
    tick();
    pulse_update(4, 16);
    fill(16, 5);
    run_frame(4, 4, -1, 0, 0, -1, 1'b0, ie, bs);
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b want 1", bs); end
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL basic_irq_latency got %0b want 1", ie); end
    checks++; if (stat_motion_pixels !== CW'(16)) begin errors++; $display("FAIL basic_pixels got %0d want 16", stat_motion_pixels); end
    checks++; if (stat_sum !== AW'(80)) begin errors++; $display("FAIL basic_sum got %0d want 80", stat_sum); end
    checks++; if (stat_motion !== 1'b1) begin errors++; $display("FAIL basic_motion got %0b want 1", stat_motion); end
    checks++; if (stat_frame_count !== FW'(1)) begin errors++; $display("FAIL basic_fcnt got %0d want 1", stat_frame_count); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_clear got %0b want 0", irq); end
    checks++; if (irq_cnt != 1) begin errors++; $display("FAIL basic_irq_count got %0d want 1", irq_cnt); end
    checks++; if (ack_cnt != 1) begin errors++; $display("FAIL basic_ack_count got %0d want 1", ack_cnt); end
  endtask

  task automatic test_frame_th();
    logic ie, bs;
    pulse_update(4, 17);
    fill(16, 5);
    run_frame(4, 4, -1, 0, 0, -1, 1'b0, ie, bs);
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL fth_irq got %0b want 1", ie); end
    checks++; if (stat_motion !== 1'b0) begin errors++; $display("FAIL fth_motion got %0b want 0", stat_motion); end
    checks++; if (stat_motion_pixels !== CW'(16)) begin errors++; $display("FAIL fth_pixels got %0d want 16", stat_motion_pixels); end
    checks++; if (stat_frame_count !== FW'(2)) begin errors++; $display("FAIL fth_fcnt got %0d want 2", stat_frame_count); end
  endtask

  task automatic test_update_mid_frame();
    logic ie, bs;
    fill(16, 5);
    run_frame(4, 4, 7, 10, 16, -1, 1'b0, ie, bs);
    checks++; if (stat_motion_pixels !== CW'(16)) begin errors++; $display("FAIL mid_old_th_pixels got %0d want 16", stat_motion_pixels); end
    checks++; if (ack_cnt != 2) begin errors++; $display("FAIL mid_no_early_ack got %0d want 2", ack_cnt); end
    run_frame(4, 4, -1, 0, 0, -1, 1'b0, ie, bs);
    checks++; if (ack_cnt != 3) begin errors++; $display("FAIL mid_ack_at_sof got %0d want 3", ack_cnt); end
    checks++; if (stat_motion_pixels !== CW'(0)) begin errors++; $display("FAIL mid_new_th_pixels got %0d want 0", stat_motion_pixels); end
    checks++; if (stat_sum !== AW'(80)) begin errors++; $display("FAIL mid_sum got %0d want 80", stat_sum); end
  endtask

  task automatic test_abort();
    logic ie, bs;
    int irq0;
    irq0 = irq_cnt;
    start_partial(5);
    checks++; if (stat_busy !== 1'b1) begin errors++; $display("FAIL abort_busy got %0b want 1", stat_busy); end
    fill(4, 12);
    run_frame(2, 2, -1, 0, 0, -1, 1'b0, ie, bs);
    checks++; if (stat_abort_count !== FW'(1)) begin errors++; $display("FAIL abort_count got %0d want 1", stat_abort_count); end
    checks++; if (irq_cnt != irq0 + 1) begin errors++; $display("FAIL abort_irq_count got %0d want %0d", irq_cnt, irq0 + 1); end
    checks++; if (stat_frame_count !== FW'(5)) begin errors++; $display("FAIL abort_fcnt got %0d want 5", stat_frame_count); end
    checks++; if (stat_sum !== AW'(48)) begin errors++; $display("FAIL abort_restart_sum got %0d want 48", stat_sum); end
  endtask

  task automatic test_abort_keeps_stats();
    start_partial(3);
    start_partial(4);
    checks++; if (stat_abort_count !== FW'(2)) begin errors++; $display("FAIL keep_abort_count got %0d want 2", stat_abort_count); end
    checks++; if (stat_sum !== AW'(48)) begin errors++; $display("FAIL keep_sum got %0d want 48", stat_sum); end
    checks++; if (stat_motion_pixels !== CW'(4)) begin errors++; $display("FAIL keep_pixels got %0d want 4", stat_motion_pixels); end
  endtask

  task automatic test_one_pixel();
    logic ie, bs;
    fill(1, 1023);
    run_frame(1, 1, -1, 0, 0, -1, 1'b0, ie, bs);
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL one_irq got %0b want 1", ie); end
    checks++; if (bs !== 1'b0) begin errors++; $display("FAIL one_busy got %0b want 0", bs); end
    checks++; if (stat_sum !== AW'(1023)) begin errors++; $display("FAIL one_sum got %0d want 1023", stat_sum); end
    checks++; if (stat_motion_pixels !== CW'(1)) begin errors++; $display("FAIL one_pixels got %0d want 1", stat_motion_pixels); end
    checks++; if (stat_abort_count !== FW'(3)) begin errors++; $display("FAIL one_abort_count got %0d want 3", stat_abort_count); end
  endtask

  task automatic test_saturation();
    logic ie, bs;
    pulse_update(0, 31);
    fill(36, 1023);
    run_frame(6, 6, -1, 0, 0, -1, 1'b0, ie, bs);
    checks++; if (stat_motion_pixels !== CW'(31)) begin errors++; $display("FAIL sat_pixels got %0d want 31", stat_motion_pixels); end
    checks++; if (stat_sum !== AW'(4095)) begin errors++; $display("FAIL sat_sum got %0d want 4095", stat_sum); end
    checks++; if (stat_motion !== 1'b1) begin errors++; $display("FAIL sat_motion got %0b want 1", stat_motion); end
  endtask

  task automatic test_random();
    logic ie, bs;
    int w, h, n, upd;
    for (int f = 0; f < 14; f++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 6);
      n = w * h;
      for (int i = 0; i < n; i++) begin
        px_sd[i] = $urandom_range(0, 1023);
        px_de[i] = ($urandom_range(0, 4) != 0);
      end
      upd = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame(w, h, upd, $urandom_range(100, 900), $urandom_range(0, 31), -1, 1'b1, ie, bs);
      checks++; if (ie !== 1'b1) begin errors++; $display("FAIL rnd%0d_irq got %0b want 1", f, ie); end
      checks++; if (bs !== (n > 1)) begin errors++; $display("FAIL rnd%0d_busy got %0b want %0b", f, bs, n > 1); end
      checks++; if (stat_motion_pixels !== CW'(m_cnt_st)) begin errors++; $display("FAIL rnd%0d_pixels got %0d want %0d", f, stat_motion_pixels, m_cnt_st); end
      checks++; if (stat_sum !== AW'(m_sum_st)) begin errors++; $display("FAIL rnd%0d_sum got %0d want %0d", f, stat_sum, m_sum_st); end
      checks++; if (stat_motion !== m_mot_st) begin errors++; $display("FAIL rnd%0d_motion got %0b want %0b", f, stat_motion, m_mot_st); end
      checks++; if (stat_frame_count !== FW'(m_fc)) begin errors++; $display("FAIL rnd%0d_fcnt got %0d want %0d", f, stat_frame_count, m_fc); end
      checks++; if (stat_abort_count !== FW'(m_ac)) begin errors++; $display("FAIL rnd%0d_acnt got %0d want %0d", f, stat_abort_count, m_ac); end
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rnd%0d_irq_clear got %0b want 0", f, irq); end
      checks++; if (irq_cnt != m_irq) begin errors++; $display("FAIL rnd%0d_irq_count got %0d want %0d", f, irq_cnt, m_irq); end
      checks++; if (ack_cnt != m_ack) begin errors++; $display("FAIL rnd%0d_ack_count got %0d want %0d", f, ack_cnt, m_ack); end
    end
  endtask

  task automatic test_enable_drop_and_reset();
    logic ie, bs;
    int fc0, irq0;
    for (int i = 0; i < 9; i++) begin
      px_sd[i] = $urandom_range(0, 1023);
      px_de[i] = 1'b1;
    end
    run_frame(3, 3, -1, 0, 0, 4, 1'b0, ie, bs);
    checks++; if (ie !== 1'b1) begin errors++; $display("FAIL drop_irq got %0b want 1", ie); end
    checks++; if (stat_sum !== AW'(m_sum_st)) begin errors++; $display("FAIL drop_sum got %0d want %0d", stat_sum, m_sum_st); end
    tick();
    checks++; if (stat_busy !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got %0b want 0", stat_busy); end
    fc0  = m_fc;
    irq0 = irq_cnt;
    drive_beat(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1023, 1'b0);
    tick();
    checks++; if (irq_cnt != irq0) begin errors++; $display("FAIL idle_sof_irq got %0d want %0d", irq_cnt, irq0); end
    checks++; if (stat_frame_count !== FW'(fc0)) begin errors++; $display("FAIL idle_sof_fcnt got %0d want %0d", stat_frame_count, fc0); end

    ctl_enable = 1'b1;
    tick();
    start_partial(3);
    cke   = 1'b0;
    reset = 1'b1;
    tick();
    checks++; if (stat_busy !== 1'b0) begin errors++; $display("FAIL rst_cke0_busy got %0b want 0", stat_busy); end
    checks++; if (stat_frame_count !== '0) begin errors++; $display("FAIL rst_cke0_fcnt got %0d want 0", stat_frame_count); end
    checks++; if (stat_abort_count !== '0) begin errors++; $display("FAIL rst_cke0_acnt got %0d want 0", stat_abort_count); end
    checks++; if (stat_sum !== '0) begin errors++; $display("FAIL rst_cke0_sum got %0d want 0", stat_sum); end
    checks++; if (stat_motion !== 1'b0) begin errors++; $display("FAIL rst_cke0_motion got %0b want 0", stat_motion); end
    reset = 1'b0;
    cke   = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      px_sd[i] = $urandom_range(0, 3);
      px_de[i] = 1'b1;
    end
    run_frame(2, 2, -1, 0, 0, -1, 1'b0, ie, bs);
    checks++; if (stat_motion_pixels !== CW'(m_cnt_st)) begin errors++; $display("FAIL post_rst_pixels got %0d want %0d", stat_motion_pixels, m_cnt_st); end
    checks++; if (stat_frame_count !== FW'(1)) begin errors++; $display("FAIL post_rst_fcnt got %0d want 1", stat_frame_count); end
    checks++; if (ack_cnt != 0) begin errors++; $display("FAIL post_rst_ack got %0d want 0", ack_cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_frame_th();
    test_update_mid_frame();
    test_abort();
    test_abort_keeps_stats();
    test_one_pixel();
    test_saturation();
    test_random();
    test_enable_drop_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
